// File: rtl/note_scheduler.sv
// Note scheduler: buffers CPU note commands in a small FIFO and drives the tone
// generator with each note for its duration, followed by an optional silent gap.
module note_scheduler #(
    parameter int unsigned NOTE_W  = 8,
    parameter int unsigned DUR_W   = 16,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned GAP_CYC = 0
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_cmd_valid,
    output logic                   o_cmd_ready,
    input  logic [NOTE_W-1:0]      i_cmd_note,
    input  logic [DUR_W-1:0]       i_cmd_dur,
    input  logic                   i_flush,
    output logic                   o_tone_en,
    output logic [NOTE_W-1:0]      o_tone_note,
    output logic                   o_done,
    output logic                   o_busy,
    output logic [$clog2(DEPTH):0] o_fifo_count
);

    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int unsigned GAP_LOAD = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DUR_W-1:0]    r_timer;
    logic [DUR_W-1:0]    w_timer_nxt;
    logic [GAP_W-1:0]    r_gap;
    logic [GAP_W-1:0]    w_gap_nxt;
    logic [PTR_W-1:0]    r_wptr;
    logic [PTR_W-1:0]    r_rptr;
    logic [CNT_W-1:0]    r_count;
    logic [NOTE_W-1:0]   r_mem_note [DEPTH];
    logic [DUR_W-1:0]    r_mem_dur  [DEPTH];
    logic                r_tone_en;
    logic [NOTE_W-1:0]   r_tone_note;
    logic                r_done;
    logic [NOTE_W-1:0]   w_tone_note_nxt;
    logic                w_full;
    logic                w_has;
    logic                w_push;
    logic                w_pop;
    logic [NOTE_W-1:0]   w_head_note;
    logic [DUR_W-1:0]    w_head_dur;

    // FIFO status; a full queue refuses pushes even when a pop lands on the same edge
    always_comb begin
        w_full      = (r_count == CNT_W'(DEPTH));
        w_has       = (r_count != '0);
        w_head_note = r_mem_note[r_rptr];
        w_head_dur  = r_mem_dur[r_rptr];
        o_cmd_ready = !w_full && !i_flush;
        w_push      = i_cmd_valid && o_cmd_ready;
        o_busy      = (r_state != S_IDLE) || w_has;
    end

    // Next state, timers and pop decision; flush overrides everything
    always_comb begin
        w_state_nxt     = r_state;
        w_timer_nxt     = r_timer;
        w_gap_nxt       = r_gap;
        w_pop           = 1'b0;
        w_tone_note_nxt = r_tone_note;
        case (r_state)
            S_IDLE: begin
                w_pop = w_has;
            end
            S_PLAY: begin
                if (r_timer != '0) begin
                    w_timer_nxt = r_timer - DUR_W'(1);
                end else if (GAP_CYC > 0) begin
                    w_state_nxt = S_GAP;
                    w_gap_nxt   = GAP_W'(GAP_LOAD);
                end else if (w_has) begin
                    w_pop = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_GAP: begin
                if (r_gap != '0) begin
                    w_gap_nxt = r_gap - GAP_W'(1);
                end else if (w_has) begin
                    w_pop = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_pop) begin
            w_state_nxt     = S_PLAY;
            w_timer_nxt     = (w_head_dur == '0) ? '0 : w_head_dur - DUR_W'(1);
            w_tone_note_nxt = w_head_note;
        end
        if (w_state_nxt != S_PLAY) begin
            w_tone_note_nxt = '0;
        end
        if (i_flush) begin
            w_state_nxt     = S_IDLE;
            w_pop           = 1'b0;
            w_tone_note_nxt = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_gap       <= '0;
            r_tone_en   <= 1'b0;
            r_tone_note <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_gap       <= w_gap_nxt;
            r_tone_en   <= (w_state_nxt == S_PLAY);
            r_tone_note <= w_tone_note_nxt;
            r_done      <= (w_state_nxt == S_PLAY) && (w_timer_nxt == '0);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_note[r_wptr] <= i_cmd_note;
            r_mem_dur[r_wptr]  <= i_cmd_dur;
        end
    end

    assign o_tone_en    = r_tone_en;
    assign o_tone_note  = r_tone_note;
    assign o_done       = r_done;
    assign o_fifo_count = r_count;

endmodule
